// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Pipeline-boundary register with a valid/ready handshake and a 2-entry
//   skid buffer. One instance sits on each stage boundary of the RV32 core
//   (IF/ID, ID/EX, EX/MEM, MEM/WB).
//
//   in_ready is a function of registered state only (the skid entry being
//   free), so it has no combinational path from out_ready. When the
//   consumer stalls, the word already in flight lands in the skid entry.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears all entries and stall_cnt
//   flush      discards held entries and any word offered this cycle
//   stall      hazard-unit hold, blocks draining like out_ready=0
//   in_valid   upstream word available
//   in_data    upstream payload [DATA_W]
//   in_ready   stage can take a word
//   out_valid  stage presents a word
//   out_data   presented payload, BUBBLE when nothing is held
//   out_ready  downstream takes the word
//   occupancy  entries held, 0..2
//   stall_cnt  saturating count of cycles a held word was blocked
module pipe_stage_reg #(
  parameter int unsigned       DATA_W = 64,
  parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}},
  parameter int unsigned       CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    if (&val) sat_inc = val;
    else      sat_inc = val + 1'b1;
  endfunction

  logic              main_v;
  logic [DATA_W-1:0] main_d;
  logic              skid_v;
  logic [DATA_W-1:0] skid_d;

  logic rdy;
  logic accept;
  logic drain;

  assign rdy    = out_ready & ~stall;
  assign accept = in_valid & in_ready;
  assign drain  = main_v & rdy;

  assign in_ready  = ~skid_v;
  assign out_valid = main_v;
  assign out_data  = main_v ? main_d : BUBBLE;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

  // Output register, skid entry and stall counter. Flush outranks stall,
  // so a flushed cycle is never counted as blocked.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      main_d    <= BUBBLE;
      skid_d    <= BUBBLE;
      stall_cnt <= '0;
    end else begin
      if (main_v && !rdy && !flush)
        stall_cnt <= sat_inc(stall_cnt);

      if (flush) begin
        main_v <= 1'b0;
        skid_v <= 1'b0;
        main_d <= BUBBLE;
        skid_d <= BUBBLE;
      end else if (!main_v) begin
        if (accept) begin
          main_v <= 1'b1;
          main_d <= in_data;
        end
      end else if (!skid_v) begin
        if (drain && accept) begin
          main_d <= in_data;
        end else if (drain) begin
          main_v <= 1'b0;
        end else if (accept) begin
          skid_v <= 1'b1;
          skid_d <= in_data;
        end
      end else if (drain) begin
        // FULL: the skid word moves up to the output register.
        main_d <= skid_d;
        skid_v <= 1'b0;
      end
    end
  end

  // The skid entry is only ever filled behind a held output word.
  assert property (@(posedge clk) disable iff (reset) !(skid_v && !main_v))
    else $error("pipe_stage_reg: skid_v set while main_v clear");

endmodule
